// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port integer register file: default geometry,
// ABI argument register indices and the ecall service codes.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  localparam int A0_IDX = 10;
  localparam int A1_IDX = 11;

  localparam int ECALL_PRINT = 1;
  localparam int ECALL_STOP  = 0;

  typedef enum logic [1:0] {
    ECALL_NONE,
    ECALL_DO_PRINT,
    ECALL_DO_STOP
  } ecall_act_e;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Priority match of one read index against all write ports; the
// highest-numbered matching port supplies the forwarded data.
module regfile_bypass_mux #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NWR  = 2
) (
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_idx,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [AW-1:0]       rd_idx,
  output logic                hit,
  output logic [XLEN-1:0]     data
);

  // NOTE: every output gets a default before the loop so no latch is inferred;
  // later iterations overwrite earlier ones, which gives the high port priority.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && (wr_idx[p*AW +: AW] == rd_idx)) begin
        hit  = 1'b1;
        data = wr_data[p*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with same-cycle bypass, a pending
// scoreboard for hazard detection and registered ecall decode (print / halt).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_idx,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD*AW-1:0]   rd_idx,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_idx,
  input  logic                ecall_sig,
  output logic                halt,
  output logic                print_flag
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;
  logic             halt_q;
  logic             print_q;

  logic [NWR-1:0]   wr_acc;
  logic             alloc_acc;

  // A write or allocation only counts when it targets a real register and the
  // core has not been halted; bypass uses the same qualified enables.
  always_comb begin
    for (int p = 0; p < NWR; p++) begin
      wr_acc[p] = wr_en[p] && !halt_q && (wr_idx[p*AW +: AW] != '0);
    end
  end

  assign alloc_acc = alloc_en && !halt_q && (alloc_idx != '0);

  // NOTE: the architectural state must come up as zero, so the array is reset
  // explicitly rather than left to power-up contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments; with several ports on one index the
      // last one scheduled (highest port) is the value that lands.
      for (int p = 0; p < NWR; p++) begin
        if (wr_acc[p]) begin
          regs[wr_idx[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Clears from writes are scheduled first so a same-cycle alloc to the same
  // index leaves the register pending on its newer producer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_acc[p]) begin
          pending[wr_idx[p*AW +: AW]] <= 1'b0;
        end
      end
      if (alloc_acc) begin
        pending[alloc_idx] <= 1'b1;
      end
    end
  end

  logic [XLEN-1:0] a0_val;
  logic [XLEN-1:0] a1_val;

  generate
    if (NREGS > A1_IDX) begin : g_abi
      assign a0_val = regs[A0_IDX];
      assign a1_val = regs[A1_IDX];
    end else begin : g_no_abi
      // Too few registers for the argument ABI: ecall never decodes.
      assign a0_val = '1;
      assign a1_val = '1;
    end
  endgenerate

  ecall_act_e ecall_act;

  always_comb begin
    ecall_act = ECALL_NONE;
    if (ecall_sig && (a0_val == '0)) begin
      if (a1_val == XLEN'(ECALL_PRINT)) begin
        ecall_act = ECALL_DO_PRINT;
      end else if (a1_val == XLEN'(ECALL_STOP)) begin
        ecall_act = ECALL_DO_STOP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_q  <= 1'b0;
      print_q <= 1'b0;
    end else begin
      halt_q  <= halt_q || (ecall_act == ECALL_DO_STOP);
      print_q <= !halt_q && (ecall_act == ECALL_DO_PRINT);
    end
  end

  assign halt       = halt_q;
  assign print_flag = print_q && !halt_q;

  generate
    for (genvar r = 0; r < NRD; r++) begin : g_rd
      logic [AW-1:0]   ridx;
      logic            hit;
      logic            fwd;
      logic [XLEN-1:0] fwd_data;

      assign ridx = rd_idx[r*AW +: AW];

      regfile_bypass_mux #(
        .XLEN (XLEN),
        .AW   (AW),
        .NWR  (NWR)
      ) u_bypass (
        .wr_en   (wr_acc),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_idx  (ridx),
        .hit     (hit),
        .data    (fwd_data)
      );

      assign fwd = (BYPASS != 0) && hit;

      assign rd_data[r*XLEN +: XLEN] = (ridx == '0) ? '0 :
                                       fwd          ? fwd_data :
                                                      regs[ridx];
      assign rd_busy[r] = pending[ridx] && !fwd;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance
// share stimulus and are checked every cycle against an architectural model.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NWR-1:0]      wr_en = '0;
  logic [NWR*AW-1:0]   wr_idx = '0;
  logic [NWR*XLEN-1:0] wr_data = '0;
  logic [NRD*AW-1:0]   rd_idx = '0;
  logic                alloc_en = 1'b0;
  logic [AW-1:0]       alloc_idx = '0;
  logic                ecall_sig = 1'b0;

  logic [NRD*XLEN-1:0] rd_data_b1, rd_data_b0;
  logic [NRD-1:0]      rd_busy_b1, rd_busy_b0;
  logic                halt_b1, halt_b0, print_b1, print_b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(32), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_b1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_data(rd_data_b1), .rd_busy(rd_busy_b1),
    .alloc_en(alloc_en), .alloc_idx(alloc_idx), .ecall_sig(ecall_sig),
    .halt(halt_b1), .print_flag(print_b1)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(32), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_b0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_data(rd_data_b0), .rd_busy(rd_busy_b0),
    .alloc_en(alloc_en), .alloc_idx(alloc_idx), .ecall_sig(ecall_sig),
    .halt(halt_b0), .print_flag(print_b0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: register array, pending bits, halt and print state.
  logic [XLEN-1:0] m_regs [32];
  logic [31:0]     m_pending;
  logic            m_halt;
  logic            m_print;

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pending = '0;
    m_halt    = 1'b0;
    m_print   = 1'b0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
      m_pending <= '0;
      m_halt    <= 1'b0;
      m_print   <= 1'b0;
    end else begin
      if (!m_halt) begin
        for (int p = 0; p < NWR; p++) begin
          if (wr_en[p] && wr_idx[p*AW +: AW] != 0) begin
            m_regs[wr_idx[p*AW +: AW]]    <= wr_data[p*XLEN +: XLEN];
            m_pending[wr_idx[p*AW +: AW]] <= 1'b0;
          end
        end
        if (alloc_en && alloc_idx != 0) m_pending[alloc_idx] <= 1'b1;
      end
      m_print <= !m_halt && ecall_sig && m_regs[10] == 0 && m_regs[11] == 1;
      m_halt  <= m_halt || (ecall_sig && m_regs[10] == 0 && m_regs[11] == 0);
    end
  end

  function automatic logic same_cycle_hit(int r, bit byp);
    logic [AW-1:0] idx = rd_idx[r*AW +: AW];
    logic h = 1'b0;
    if (byp && !m_halt && idx != 0)
      for (int p = 0; p < NWR; p++)
        if (wr_en[p] && wr_idx[p*AW +: AW] == idx) h = 1'b1;
    return h;
  endfunction

  function automatic logic [XLEN-1:0] exp_data(int r, bit byp);
    logic [AW-1:0] idx = rd_idx[r*AW +: AW];
    logic [XLEN-1:0] v;
    if (idx == 0) return '0;
    v = m_regs[idx];
    if (same_cycle_hit(r, byp))
      for (int p = 0; p < NWR; p++)
        if (wr_en[p] && wr_idx[p*AW +: AW] == idx) v = wr_data[p*XLEN +: XLEN];
    return v;
  endfunction

  function automatic logic exp_busy(int r, bit byp);
    logic [AW-1:0] idx = rd_idx[r*AW +: AW];
    return m_pending[idx] && !same_cycle_hit(r, byp);
  endfunction

  // Compare process: every falling edge, both instances against the model.
  always @(negedge clk) begin
    for (int r = 0; r < NRD; r++) begin
      check($sformatf("b1_rd_data%0d", r), 64'(rd_data_b1[r*XLEN +: XLEN]), 64'(exp_data(r, 1'b1)));
      check($sformatf("b0_rd_data%0d", r), 64'(rd_data_b0[r*XLEN +: XLEN]), 64'(exp_data(r, 1'b0)));
      check($sformatf("b1_rd_busy%0d", r), 64'(rd_busy_b1[r]), 64'(exp_busy(r, 1'b1)));
      check($sformatf("b0_rd_busy%0d", r), 64'(rd_busy_b0[r]), 64'(exp_busy(r, 1'b0)));
    end
    check("b1_halt",  64'(halt_b1),  64'(m_halt));
    check("b0_halt",  64'(halt_b0),  64'(m_halt));
    check("b1_print", 64'(print_b1), 64'(m_print));
    check("b0_print", 64'(print_b0), 64'(m_print));
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en     = '0;
    alloc_en  = 1'b0;
    ecall_sig = 1'b0;
  endtask

  task automatic wr(input int p, input int idx, input logic [XLEN-1:0] d);
    wr_en[p]              = 1'b1;
    wr_idx[p*AW +: AW]    = AW'(idx);
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int r, input int idx);
    rd_idx[r*AW +: AW] = AW'(idx);
  endtask

  initial begin
    next();
    next();
    rst = 1'b0;

    // Reset state on every index and both ports.
    for (int i = 0; i < 32; i++) begin
      rd(0, i); rd(1, 31 - i);
      #2;
      check("rst_rd0",  64'(rd_data_b1[31:0]),  64'h0);
      check("rst_rd1",  64'(rd_data_b0[63:32]), 64'h0);
      check("rst_busy", 64'({rd_busy_b1, rd_busy_b0}), 64'h0);
      check("rst_halt", 64'(halt_b1), 64'h0);
      next();
    end

    // Write-to-read latency with and without bypass.
    wr(0, 5, 32'hDEADBEEF); rd(0, 5); rd(1, 5);
    #2;
    check("byp1_same_cycle", 64'(rd_data_b1[31:0]), 64'hDEADBEEF);
    check("byp0_same_cycle", 64'(rd_data_b0[31:0]), 64'h0);
    next(); idle();
    #2;
    check("byp0_next_cycle", 64'(rd_data_b0[31:0]), 64'hDEADBEEF);
    check("model_x5",        64'(m_regs[5]),        64'hDEADBEEF);
    next();

    // Same-index write collision, then write to x0.
    wr(0, 7, 32'h1); wr(1, 7, 32'h2); rd(1, 7);
    #2;
    check("collide_bypass", 64'(rd_data_b1[63:32]), 64'h2);
    next(); idle();
    #2;
    check("collide_x7",     64'(rd_data_b0[63:32]), 64'h2);
    check("model_x7",       64'(m_regs[7]),         64'h2);
    wr(0, 0, 32'hFF); rd(1, 0);
    #2;
    check("x0_same_cycle",  64'(rd_data_b1[63:32]), 64'h0);
    next(); idle();
    #2;
    check("x0_after",       64'(rd_data_b0[63:32]), 64'h0);
    next();

    // Scoreboard: alloc, release by write, alloc+write collision.
    alloc_en = 1'b1; alloc_idx = 5'd9; rd(0, 9); rd(1, 9);
    #2;
    check("alloc_same_cycle_busy", 64'(rd_busy_b1[0]), 64'h0);
    next(); idle();
    #2;
    check("alloc_busy_b1", 64'(rd_busy_b1[0]), 64'h1);
    check("alloc_busy_b0", 64'(rd_busy_b0[1]), 64'h1);
    next();
    wr(0, 9, 32'h55);
    #2;
    check("wr_busy_byp1", 64'(rd_busy_b1[0]),   64'h0);
    check("wr_data_byp1", 64'(rd_data_b1[31:0]), 64'h55);
    check("wr_busy_byp0", 64'(rd_busy_b0[0]),   64'h1);
    next(); idle();
    #2;
    check("released_b0", 64'(rd_busy_b0[0]), 64'h0);
    next();
    alloc_en = 1'b1; alloc_idx = 5'd9; wr(1, 9, 32'h66);
    next(); idle();
    #2;
    check("alloc_wins_b1", 64'(rd_busy_b1[0]),   64'h1);
    check("alloc_wins_b0", 64'(rd_busy_b0[1]),   64'h1);
    check("alloc_wr_data", 64'(rd_data_b0[31:0]), 64'h66);
    next();

    // Ecall print: a0 = 0, a1 = 1.
    wr(0, 10, 32'h0); wr(1, 11, 32'h1); rd(0, 10); rd(1, 11);
    next(); idle();
    ecall_sig = 1'b1;
    #2;
    check("print_not_yet", 64'(print_b1), 64'h0);
    next(); idle();
    #2;
    check("print_pulse", 64'({print_b1, print_b0}), 64'h3);
    check("print_halt",  64'(halt_b1), 64'h0);
    next();
    #2;
    check("print_one_cycle", 64'({print_b1, print_b0}), 64'h0);

    // Ecall with unrelated code has no effect.
    wr(1, 11, 32'h7);
    next(); idle();
    ecall_sig = 1'b1;
    next(); idle();
    #2;
    check("other_code", 64'({halt_b1, print_b1}), 64'h0);

    // Ecall stop: a0 = 0, a1 = 0, then writes and allocs are ignored.
    wr(1, 11, 32'h0);
    next(); idle();
    ecall_sig = 1'b1;
    next(); idle();
    #2;
    check("halt_set", 64'({halt_b1, halt_b0}), 64'h3);
    next();
    wr(0, 4, 32'h3); alloc_en = 1'b1; alloc_idx = 5'd12; rd(0, 9); rd(1, 9);
    next(); idle();
    rd(0, 4); rd(1, 12);
    #2;
    check("halt_held",     64'(halt_b0), 64'h1);
    check("halt_no_write", 64'(rd_data_b1[31:0]), 64'h0);
    check("halt_no_alloc", 64'(rd_busy_b0[1]),     64'h0);
    next();

    // Mid-operation reset overrides a same-cycle write and alloc.
    rst = 1'b1; wr(0, 5, 32'h77); alloc_en = 1'b1; alloc_idx = 5'd6; rd(0, 7); rd(1, 9);
    #2;
    check("rst_clears_halt", 64'({halt_b1, halt_b0}), 64'h0);
    check("rst_clears_x7",   64'(rd_data_b0[31:0]),   64'h0);
    next();
    next(); idle(); rst = 1'b0;
    rd(0, 5); rd(1, 6);
    #2;
    check("rst_x5",      64'(rd_data_b0[31:0]), 64'h0);
    check("rst_x6_busy", 64'(rd_busy_b0[1]),    64'h0);
    next();

    // Post-reset operation resumes.
    wr(1, 3, 32'h12345678); rd(0, 3);
    next(); idle();
    #2;
    check("post_rst_wr", 64'(rd_data_b0[31:0]), 64'h12345678);
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
